// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the IF/ME unified-memory port arbiter.
package mem_arb_pkg;

    localparam int AW_DEFAULT = 32;
    localparam int DW_DEFAULT = 32;
    localparam int PERF_W     = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        IF   = 2'd1,
        ME   = 2'd2
    } arb_owner_t;

    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/arb_perf_counters.sv
// Saturating event counters for grants and IF-loses-to-ME conflicts.
module arb_perf_counters
    import mem_arb_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              if_inc,
    input  logic              me_inc,
    input  logic              conflict_inc,
    output logic [PERF_W-1:0] if_cnt,
    output logic [PERF_W-1:0] me_cnt,
    output logic [PERF_W-1:0] conflict_cnt
);

    always_ff @(posedge CLK) begin
        if (RST) begin
            if_cnt       <= '0;
            me_cnt       <= '0;
            conflict_cnt <= '0;
        end else begin
            if (if_inc)       if_cnt       <= sat_inc(if_cnt);
            if (me_inc)       me_cnt       <= sat_inc(me_cnt);
            if (conflict_inc) conflict_cnt <= sat_inc(conflict_cnt);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported memory between fetch (IF) and data (ME), ME first.
// Define MEM_ARB_PERF_EN to add saturating grant/conflict counters.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW = AW_DEFAULT,
    parameter int DW = DW_DEFAULT
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    output logic          if_stall,
    input  logic          me_req,
    input  logic          me_we,
    input  logic [AW-1:0] me_addr,
    input  logic [DW-1:0] me_wdata,
    output logic          me_gnt,
    output logic          me_rvalid,
    output logic [DW-1:0] me_rdata,
    output logic          me_stall,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_if_cnt,
    output logic [PERF_W-1:0] perf_me_cnt,
    output logic [PERF_W-1:0] perf_conflict_cnt
`endif
);

    arb_state_t state;
    arb_owner_t owner;
    logic       arb_cycle;
    logic       if_eligible;
    logic       me_eligible;

    // In DONE the owner's req still belongs to the finished access, so it is masked.
    // NOTE: every signal is assigned on every path of this block, so no latch is inferred.
    always_comb begin
        arb_cycle   = (state == IDLE) || (state == DONE);
        me_eligible = me_req && !((state == DONE) && (owner == ME));
        if_eligible = if_req && !((state == DONE) && (owner == IF));
        me_gnt      = arb_cycle && me_eligible && !RST;
        if_gnt      = arb_cycle && if_eligible && !me_eligible && !RST;
    end

    assign if_stall = if_req & ~if_rvalid;
    assign me_stall = me_req & ~me_rvalid;

    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            owner     <= NONE;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rvalid <= 1'b0;
            if_rdata  <= '0;
            me_rvalid <= 1'b0;
            me_rdata  <= '0;
        end else begin
            if_rvalid <= 1'b0;
            me_rvalid <= 1'b0;
            case (state)
                BUSY: begin
                    if (mem_ack) begin
                        state  <= DONE;
                        mem_en <= 1'b0;
                        mem_we <= 1'b0;
                        if (owner == ME) begin
                            me_rvalid <= 1'b1;
                            me_rdata  <= mem_we ? '0 : mem_rdata;
                        end else begin
                            if_rvalid <= 1'b1;
                            if_rdata  <= mem_rdata;
                        end
                    end
                end
                default: begin
                    if (me_gnt) begin
                        state     <= BUSY;
                        owner     <= ME;
                        mem_en    <= 1'b1;
                        mem_we    <= me_we;
                        mem_addr  <= me_addr;
                        mem_wdata <= me_we ? me_wdata : '0;
                    end else if (if_gnt) begin
                        state     <= BUSY;
                        owner     <= IF;
                        mem_en    <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= if_addr;
                        mem_wdata <= '0;
                    end else begin
                        state <= IDLE;
                        owner <= NONE;
                    end
                end
            endcase
        end
    end

`ifdef MEM_ARB_PERF_EN
    logic conflict;
    assign conflict = arb_cycle && if_eligible && me_eligible && !RST;

    arb_perf_counters u_perf (
        .CLK          (CLK),
        .RST          (RST),
        .if_inc       (if_gnt),
        .me_inc       (me_gnt),
        .conflict_inc (conflict),
        .if_cnt       (perf_if_cnt),
        .me_cnt       (perf_me_cnt),
        .conflict_cnt (perf_conflict_cnt)
    );
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_mem_port_arbiter;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        if_req = 1'b0, me_req = 1'b0, me_we = 1'b0;
    logic [31:0] if_addr = '0, me_addr = '0, me_wdata = '0;
    logic        if_gnt, if_rvalid, if_stall, me_gnt, me_rvalid, me_stall;
    logic [31:0] if_rdata, me_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_if_cnt, perf_me_cnt, perf_conflict_cnt;
`endif

    mem_port_arbiter dut (
        .CLK(CLK), .RST(RST),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
        .if_rdata(if_rdata), .if_stall(if_stall),
        .me_req(me_req), .me_we(me_we), .me_addr(me_addr), .me_wdata(me_wdata),
        .me_gnt(me_gnt), .me_rvalid(me_rvalid), .me_rdata(me_rdata), .me_stall(me_stall),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
`ifdef MEM_ARB_PERF_EN
        , .perf_if_cnt(perf_if_cnt), .perf_me_cnt(perf_me_cnt),
        .perf_conflict_cnt(perf_conflict_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Memory responder: latency fixed or random, optional ack suppression, spurious acks when idle.
    logic        rand_lat = 1'b0;
    logic        hold_ack = 1'b0;
    int          fixed_lat = 0;
    logic [31:0] dir_rdata = '0;
    bit          in_acc = 1'b0;
    int          lat = 0;

    initial begin
        forever begin
            step();
            mem_ack   = 1'b0;
            mem_rdata = rand_lat ? $urandom : dir_rdata;
            if (mem_en && !hold_ack) begin
                if (!in_acc) begin
                    in_acc = 1'b1;
                    lat    = rand_lat ? int'($urandom_range(0, 3)) : fixed_lat;
                end
                if (lat == 0) begin
                    mem_ack = 1'b1;
                    in_acc  = 1'b0;
                end else begin
                    lat--;
                end
            end else if (!mem_en) begin
                in_acc = 1'b0;
                if (rand_lat) mem_ack = ($urandom % 8 == 0);
            end
        end
    end

    // Transaction-level model: at most one access outstanding; the port completing now
    // (rvalid high) cannot win this cycle's arbitration.
    bit          m_busy = 0, m_own_me = 0, m_we = 0, m_if_rv = 0, m_me_rv = 0;
    logic [31:0] m_addr = '0, m_wdata = '0, m_if_rd = '0, m_me_rd = '0;
    bit          me_ok, if_ok, can_issue, e_me_gnt, e_if_gnt;

    initial begin
        forever begin
            @(negedge CLK);
            me_ok     = me_req && !m_me_rv;
            if_ok     = if_req && !m_if_rv;
            can_issue = !m_busy && !RST;
            e_me_gnt  = can_issue && me_ok;
            e_if_gnt  = can_issue && if_ok && !me_ok;

            check("me_gnt",    32'(me_gnt),    32'(e_me_gnt));
            check("if_gnt",    32'(if_gnt),    32'(e_if_gnt));
            check("me_rvalid", 32'(me_rvalid), 32'(m_me_rv));
            check("if_rvalid", 32'(if_rvalid), 32'(m_if_rv));
            check("me_stall",  32'(me_stall),  32'(me_req && !m_me_rv));
            check("if_stall",  32'(if_stall),  32'(if_req && !m_if_rv));
            check("mem_en",    32'(mem_en),    32'(m_busy));
            if (m_busy) begin
                check("mem_addr", mem_addr, m_addr);
                check("mem_we",   32'(mem_we), 32'(m_we));
                if (m_we) check("mem_wdata", mem_wdata, m_wdata);
            end
            if (m_me_rv) check("me_rdata", me_rdata, m_me_rd);
            if (m_if_rv) check("if_rdata", if_rdata, m_if_rd);

            if (RST) begin
                m_busy = 0; m_own_me = 0; m_we = 0; m_if_rv = 0; m_me_rv = 0;
                m_if_rd = '0; m_me_rd = '0;
            end else begin
                m_if_rv = 0;
                m_me_rv = 0;
                if (m_busy && mem_ack) begin
                    m_busy = 0;
                    if (m_own_me) begin
                        m_me_rv = 1;
                        m_me_rd = m_we ? 32'h0 : mem_rdata;
                    end else begin
                        m_if_rv = 1;
                        m_if_rd = mem_rdata;
                    end
                end else if (e_me_gnt) begin
                    m_busy = 1; m_own_me = 1; m_addr = me_addr; m_we = me_we; m_wdata = me_wdata;
                end else if (e_if_gnt) begin
                    m_busy = 1; m_own_me = 0; m_addr = if_addr; m_we = 0; m_wdata = '0;
                end
            end
        end
    end

    task automatic collision();
        fixed_lat = 0; dir_rdata = 32'h0BADF00D;
        if_req = 1; if_addr = 32'h200; me_req = 1; me_we = 0; me_addr = 32'h100;
        @(negedge CLK);
        check("col_me_gnt_first", 32'(me_gnt), 1);
        check("col_if_waits",     32'(if_gnt), 0);
        step(); @(negedge CLK);
        check("col_addr_me", mem_addr, 32'h100);
        step(); @(negedge CLK);
        check("col_me_rvalid",   32'(me_rvalid), 1);
        check("col_me_rdata",    me_rdata, 32'h0BADF00D);
        check("col_if_gnt_done", 32'(if_gnt), 1);
        check("col_if_rv_low",   32'(if_rvalid), 0);
        step(); me_req = 0; @(negedge CLK);
        check("col_addr_if", mem_addr, 32'h200);
        step(); @(negedge CLK);
        check("col_if_rvalid", 32'(if_rvalid), 1);
        check("col_me_rv_low", 32'(me_rvalid), 0);
        step(); if_req = 0;
        step();
    endtask

    bit if_done_prev = 0, me_done_prev = 0;

    initial begin
        repeat (2) step();
        @(negedge CLK);
        check("rst_mem_en",   32'(mem_en), 0);
        check("rst_if_rv",    32'(if_rvalid), 0);
        check("rst_me_rdata", me_rdata, 0);
        check("rst_if_stall", 32'(if_stall), 0);
        step(); RST = 0;
        step();

        repeat (5) collision();
`ifdef MEM_ARB_PERF_EN
        check("perf_conflict", perf_conflict_cnt, 5);
        check("perf_me",       perf_me_cnt, 5);
        check("perf_if",       perf_if_cnt, 5);
`endif

        // Single fetch, one wait state.
        fixed_lat = 1; dir_rdata = 32'h00A00093; if_req = 1; if_addr = 32'h10;
        @(negedge CLK);
        check("fetch_gnt",   32'(if_gnt), 1);
        check("fetch_stall", 32'(if_stall), 1);
        step(); @(negedge CLK);
        check("fetch_en1",  32'(mem_en), 1);
        check("fetch_addr", mem_addr, 32'h10);
        check("fetch_we",   32'(mem_we), 0);
        step(); @(negedge CLK);
        check("fetch_en2", 32'(mem_en), 1);
        step(); @(negedge CLK);
        check("fetch_rvalid",    32'(if_rvalid), 1);
        check("fetch_rdata",     if_rdata, 32'h00A00093);
        check("fetch_stall_low", 32'(if_stall), 0);
        step(); if_req = 0;
        step();

        // Store, ack in the first mem_en cycle.
        fixed_lat = 0; dir_rdata = 32'h12345678;
        me_req = 1; me_we = 1; me_addr = 32'h104; me_wdata = 32'hDEADBEEF;
        @(negedge CLK);
        check("st_gnt", 32'(me_gnt), 1);
        step(); @(negedge CLK);
        check("st_mem_we",    32'(mem_we), 1);
        check("st_mem_wdata", mem_wdata, 32'hDEADBEEF);
        check("st_mem_addr",  mem_addr, 32'h104);
        step(); @(negedge CLK);
        check("st_rvalid", 32'(me_rvalid), 1);
        check("st_rdata",  me_rdata, 0);
        step(); me_req = 0; me_we = 0;
        step();

        // Back-to-back loads with req held: one completion every 3 cycles.
        me_req = 1; me_we = 0;
        for (int k = 0; k < 3; k++) begin
            me_addr = 32'h100 + 32'(4 * k); dir_rdata = 32'h1000 + 32'(k);
            @(negedge CLK);
            check("b2b_gnt", 32'(me_gnt), 1);
            step();
            step(); @(negedge CLK);
            check("b2b_rvalid",  32'(me_rvalid), 1);
            check("b2b_rdata",   me_rdata, 32'h1000 + 32'(k));
            check("b2b_no_regnt", 32'(me_gnt), 0);
            step();
        end
        me_req = 0;
        step();

        // Reset during BUSY with the memory never acknowledging.
        hold_ack = 1; if_req = 1; if_addr = 32'h40;
        @(negedge CLK);
        check("rm_gnt", 32'(if_gnt), 1);
        step(); @(negedge CLK);
        check("rm_busy", 32'(mem_en), 1);
        step(); RST = 1; @(negedge CLK);
        check("rm_busy2", 32'(mem_en), 1);
        step(); RST = 0; if_req = 0; hold_ack = 0; @(negedge CLK);
        check("rm_en_low", 32'(mem_en), 0);
        check("rm_no_rv",  32'(if_rvalid), 0);
        step();
        fixed_lat = 0; dir_rdata = 32'h00000013; if_req = 1; if_addr = 32'h44;
        @(negedge CLK);
        check("rm_fresh_gnt", 32'(if_gnt), 1);
        step(); @(negedge CLK);
        check("rm_fresh_addr", mem_addr, 32'h44);
        step(); @(negedge CLK);
        check("rm_fresh_rv",    32'(if_rvalid), 1);
        check("rm_fresh_rdata", if_rdata, 32'h13);
        step(); if_req = 0;
        step();

        // Randomized traffic, latencies, spurious acks, dropped requests and resets.
        rand_lat = 1;
        repeat (4000) begin
            step();
            RST = ($urandom % 300 == 0);
            if (!if_req || if_done_prev) begin
                if_req  = ($urandom % 3 == 0);
                if_addr = $urandom;
            end else if ($urandom % 40 == 0) begin
                if_req = 0;
            end
            if_done_prev = if_rvalid;
            if (!me_req || me_done_prev) begin
                me_req   = ($urandom % 3 == 0);
                me_we    = $urandom % 2 == 0;
                me_addr  = $urandom;
                me_wdata = $urandom;
            end else if ($urandom % 40 == 0) begin
                me_req = 0;
            end
            me_done_prev = me_rvalid;
        end
        rand_lat = 0; RST = 0; if_req = 0; me_req = 0;
        repeat (6) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-ported unified memory in the memory system between the fetch port (IF) and the data port (ME) of the 5-stage pipeline.
- Registered request/acknowledge FSM with fixed ME-over-IF priority.
- Produces per-port stall signals that the pipeline control uses to freeze the DE/EX/ME/WB latches.

Parameters:
- AW, 32, address width in bits (byte address).
- DW, 32, data width in bits.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  reset, synchronous, active-high.
- if_req  in  1  fetch request; held until if_rvalid.
- if_addr  in  AW  fetch address; stable while if_req is high.
- if_gnt  out  1  one-cycle pulse: fetch issued to memory.
- if_rvalid  out  1  one-cycle pulse: if_rdata is valid.
- if_rdata  out  DW  fetched instruction word.
- if_stall  out  1  equals if_req & ~if_rvalid (combinational).
- me_req  in  1  data request; held until me_rvalid.
- me_we  in  1  1 = store, 0 = load.
- me_addr  in  AW  data address.
- me_wdata  in  DW  store data.
- me_gnt  out  1  one-cycle pulse: data access issued.
- me_rvalid  out  1  one-cycle pulse: load data valid, or store complete.
- me_rdata  out  DW  load data; 0 for stores.
- me_stall  out  1  equals me_req & ~me_rvalid (combinational).
- mem_en  out  1  memory access strobe; held until mem_ack.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data; valid in the mem_ack cycle.
- mem_ack  in  1  memory completion; may assert in the first mem_en cycle.

Behaviour:
- Reset values: all outputs 0 (rdata outputs 0, stalls follow inputs); state IDLE; owner NONE.
- States:
  - IDLE: arbitrate. If me_req, go to BUSY with owner ME, else if if_req, go to BUSY with owner IF, else stay in IDLE.
  - BUSY: hold mem_* stable. On mem_ack, go to DONE.
  - DONE: one cycle; pulse the owner's rvalid; arbitrate exactly as IDLE (back-to-back issue permitted).
- Issue timing:
  - Request seen in an arbitration cycle t: gnt pulses in cycle t (combinational from state and req).
  - mem_en, mem_addr, mem_we and mem_wdata are registered and present from t+1.
- Completion timing: mem_ack in cycle a; rdata is latched and rvalid pulses at a+1.
- Minimum read latency: req at t gives rvalid at t+2 (ack in the first mem_en cycle).
- Back-to-back throughput: one access per 2 cycles minimum.
- Grant rules:
  - Simultaneous if_req and me_req: ME wins; IF waits.
  - In DONE, the owner's req is ignored for that cycle, because it is still asserted for the completed transaction. The other port therefore wins DONE arbitration. The owner may re-request from the following cycle.
- Stores: mem_we=1, mem_wdata=me_wdata; me_rvalid pulses as the completion; me_rdata=0.
- IF never writes: mem_we=0 whenever the owner is IF.
- Spurious mem_ack in IDLE or DONE is ignored.
- Requester dropping req while BUSY: the access still completes; rvalid still pulses; the requester ignores it.
- RST mid-transaction (BUSY or DONE):
  - Next cycle: IDLE, mem_en=0, no rvalid, transaction dropped.
  - Memory side must tolerate an abandoned access.
- No address alignment checks; addresses pass through unmodified.

Optional Feature:
- Macro: MEM_ARB_PERF_EN.
- Defined:
  - Adds outputs perf_if_cnt, perf_me_cnt and perf_conflict_cnt, each 32 bits, saturating, cleared by RST.
  - perf_if_cnt / perf_me_cnt increment on each if_gnt / me_gnt.
  - perf_conflict_cnt increments in each arbitration cycle where both ports request and IF loses.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package mem_arb_pkg:
  - arb_state_t enum: IDLE, BUSY, DONE.
  - arb_owner_t enum: NONE, IF, ME.
  - Default AW/DW constants.
- Sub-module arb_perf_counters: three saturating counters, instantiated only under MEM_ARB_PERF_EN.
- The FSM stays in the top module.

Test Plan:
- Single fetch: if_req=1, if_addr=0x00000010, mem_ack 1 cycle after mem_en, mem_rdata=0x00A00093 -> if_gnt at t, mem_en t+1..t+2, if_rvalid at t+3 with if_rdata=0x00A00093, if_stall low at t+3.
- Collision: if_req and me_req rise together, me_we=0, me_addr=0x100 -> me_gnt first. if_gnt occurs in the DONE cycle of the ME access. Expect me_rvalid then if_rvalid, never both in one cycle.
- Store: me_we=1, me_addr=0x104, me_wdata=0xDEADBEEF, mem_ack in the first mem_en cycle -> mem_we=1, mem_wdata=0xDEADBEEF, me_rvalid at t+2 with me_rdata=0.
- Back-to-back: me_req held across 3 loads (addr 0x100, 0x104, 0x108) with if_req=0 -> me_rvalid every 3 cycles with zero-wait memory. The owner's req is ignored in DONE, so each re-issue follows the DONE cycle.
- Reset mid-op: assert RST during BUSY with mem_ack never raised -> next cycle mem_en=0, no rvalid. A fresh if_req after reset is served normally.
- MEM_ARB_PERF_EN: run the collision test 5 times -> perf_conflict_cnt=5, perf_me_cnt=5, perf_if_cnt=5.
